fetch_queue: RTL and testbench

- Sits directly upstream of the instruction memory.
- Owns the program counter and drives the word-aligned fetch address; the memory returns the instruction word combinationally in the same cycle.
- Captures each returned word, with its PC and PC+8, into a small in-order queue that feeds the decoder over a valid/ready handshake.
- Handles branch redirects (flush plus PC reload), decoder back-pressure and fetch halt.

---
 rtl/fetch_queue.sv | 101 ++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, drives the instruction memory address
// and buffers fetched words with their PC and PC+8 in an in-order queue for the decoder.
module fetch_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [31:0]               imem_addr,
  input  logic [31:0]               imem_rd,
  input  logic                      fetch_en,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_target,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic [31:0]               dec_instr,
  output logic [31:0]               dec_pc,
  output logic [31:0]               dec_pc_plus8,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;

  logic [31:0] instr_q  [DEPTH];
  logic [31:0] pc_ent_q [DEPTH];
  logic [31:0] pc8_ent_q[DEPTH];

  logic pop, push, space;
  logic unused_target_lsbs;

  assign unused_target_lsbs = ^redirect_target[1:0];

  assign dec_valid = (occ_q != '0);
  assign pop       = dec_valid & dec_ready;
  // A pop in the same cycle frees a slot, so a full queue can keep streaming.
  assign space     = (occ_q != FULL) | pop;
  assign push      = fetch_en & space & ~redirect_valid;

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (redirect_valid) begin
      pc_d     = {redirect_target[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_VECTOR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Entry payload carries no reset; validity is tracked solely by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q]   <= imem_rd;
      pc_ent_q[wr_ptr_q]  <= pc_q;
      pc8_ent_q[wr_ptr_q] <= pc_q + 32'd8;
    end
  end

  assign imem_addr    = pc_q;
  assign occupancy    = occ_q;
  assign dec_instr    = dec_valid ? instr_q[rd_ptr_q]   : 32'd0;
  assign dec_pc       = dec_valid ? pc_ent_q[rd_ptr_q]  : 32'd0;
  assign dec_pc_plus8 = dec_valid ? pc8_ent_q[rd_ptr_q] : 32'd0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, back-pressure, redirects, PC wrap and async reset.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr, imem_rd;
  logic        fetch_en, redirect_valid;
  logic [31:0] redirect_target;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc, dec_pc_plus8;
  logic [2:0]  occupancy;

  logic        reset_w;
  logic [31:0] imem_addr_w, imem_rd_w;
  logic        fetch_en_w, redirect_valid_w, dec_ready_w;
  logic [31:0] redirect_target_w;
  logic        dec_valid_w;
  logic [31:0] dec_instr_w, dec_pc_w, dec_pc_plus8_w;
  logic [2:0]  occupancy_w;

  int n_checks;
  int n_errors;

  assign imem_rd   = 32'hE000_0000 + (imem_addr >> 2);
  assign imem_rd_w = 32'hE000_0000 + (imem_addr_w >> 2);

  fetch_queue #(.DEPTH(4), .RESET_VECTOR(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_pc_plus8(dec_pc_plus8), .occupancy(occupancy)
  );

  fetch_queue #(.DEPTH(4), .RESET_VECTOR(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(reset_w), .imem_addr(imem_addr_w), .imem_rd(imem_rd_w),
    .fetch_en(fetch_en_w), .redirect_valid(redirect_valid_w), .redirect_target(redirect_target_w),
    .dec_valid(dec_valid_w), .dec_ready(dec_ready_w), .dec_instr(dec_instr_w),
    .dec_pc(dec_pc_w), .dec_pc_plus8(dec_pc_plus8_w), .occupancy(occupancy_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0; fetch_en = 1'b1; dec_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    reset_w = 1'b0; fetch_en_w = 1'b1; dec_ready_w = 1'b1;
    redirect_valid_w = 1'b0; redirect_target_w = 32'h0;

    // Reset state
    #2;
    check_eq("rst_valid", {31'd0, dec_valid}, 32'd0);
    check_eq("rst_occ", {29'd0, occupancy}, 32'd0);
    check_eq("rst_instr", dec_instr, 32'd0);
    check_eq("rst_pc", dec_pc, 32'd0);
    check_eq("rst_pc8", dec_pc_plus8, 32'd0);
    reset = 1'b1;
    check_eq("c1_addr", imem_addr, 32'h0);

    // Streaming, one instruction per cycle
    tick();
    check_eq("s_valid", {31'd0, dec_valid}, 32'd1);
    check_eq("s_instr0", dec_instr, 32'hE000_0000);
    check_eq("s_pc0", dec_pc, 32'h0);
    check_eq("s_pc8_0", dec_pc_plus8, 32'h8);
    check_eq("s_addr1", imem_addr, 32'h4);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("s_pc", dec_pc, 32'(4 * k));
      check_eq("s_instr", dec_instr, 32'hE000_0000 + 32'(k));
      check_eq("s_occ", {29'd0, occupancy}, 32'd1);
    end

    // Back-pressure fills the queue, then drains with no gap
    dec_ready = 1'b0;
    pulse_reset();
    repeat (4) tick();
    check_eq("bp_occ", {29'd0, occupancy}, 32'd4);
    check_eq("bp_addr", imem_addr, 32'h10);
    check_eq("bp_instr", dec_instr, 32'hE000_0000);
    tick();
    check_eq("full_occ", {29'd0, occupancy}, 32'd4);
    check_eq("full_addr", imem_addr, 32'h10);
    check_eq("full_instr", dec_instr, 32'hE000_0000);
    dec_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_eq("drain_pc", dec_pc, 32'(4 * k));
      check_eq("drain_instr", dec_instr, 32'hE000_0000 + 32'(k));
    end
    check_eq("drain_occ", {29'd0, occupancy}, 32'd4);
    check_eq("drain_addr", imem_addr, 32'h28);

    // Redirect with three entries queued
    dec_ready = 1'b0;
    pulse_reset();
    repeat (3) tick();
    check_eq("r3_occ", {29'd0, occupancy}, 32'd3);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0043;
    tick();
    redirect_valid = 1'b0;
    check_eq("r_occ", {29'd0, occupancy}, 32'd0);
    check_eq("r_valid", {31'd0, dec_valid}, 32'd0);
    check_eq("r_addr", imem_addr, 32'h40);
    check_eq("r_instr", dec_instr, 32'd0);
    tick();
    check_eq("r_pc", dec_pc, 32'h40);
    check_eq("r_pc8", dec_pc_plus8, 32'h48);
    check_eq("r_instr2", dec_instr, 32'hE000_0010);
    check_eq("r_occ2", {29'd0, occupancy}, 32'd1);

    // Redirect alongside a pop on a full queue
    pulse_reset();
    repeat (4) tick();
    check_eq("rf_occ", {29'd0, occupancy}, 32'd4);
    dec_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    check_eq("rf_occ0", {29'd0, occupancy}, 32'd0);
    check_eq("rf_valid", {31'd0, dec_valid}, 32'd0);
    check_eq("rf_addr", imem_addr, 32'h100);
    tick();
    check_eq("rf_pc", dec_pc, 32'h100);
    check_eq("rf_instr", dec_instr, 32'hE000_0040);
    check_eq("rf_occ1", {29'd0, occupancy}, 32'd1);

    // fetch_en=0 still lets the decoder pop; empty pop is harmless
    fetch_en = 1'b0;
    tick();
    check_eq("fe0_occ", {29'd0, occupancy}, 32'd0);
    check_eq("fe0_pc", dec_pc, 32'd0);
    check_eq("fe0_addr", imem_addr, 32'h104);
    tick();
    check_eq("empty_occ", {29'd0, occupancy}, 32'd0);
    check_eq("empty_addr", imem_addr, 32'h104);

    // PC wrap through 2^32
    reset_w = 1'b1;
    check_eq("w_addr0", imem_addr_w, 32'hFFFF_FFF8);
    tick();
    check_eq("w_pc0", dec_pc_w, 32'hFFFF_FFF8);
    check_eq("w_pc8_0", dec_pc_plus8_w, 32'h0);
    tick();
    check_eq("w_pc1", dec_pc_w, 32'hFFFF_FFFC);
    check_eq("w_pc8_1", dec_pc_plus8_w, 32'h4);
    tick();
    check_eq("w_pc2", dec_pc_w, 32'h0);
    check_eq("w_pc8_2", dec_pc_plus8_w, 32'h8);

    // Asynchronous reset mid-stream
    fetch_en = 1'b1; dec_ready = 1'b0;
    pulse_reset();
    repeat (2) tick();
    check_eq("ar_occ2", {29'd0, occupancy}, 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_valid", {31'd0, dec_valid}, 32'd0);
    check_eq("ar_addr", imem_addr, 32'h0);
    check_eq("ar_occ", {29'd0, occupancy}, 32'd0);
    check_eq("ar_instr", dec_instr, 32'd0);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
